keccak_pad: RTL and testbench
=============================

# keccak_pad

Absorb-side input stage for the SHA3-256 datapath. Accepts a message as a stream of 64-bit lanes and applies SHA3 padding (domain byte 0x06, final bit 0x80). Packs the lanes into rate-sized blocks in the 5x5xWIDTH state format. Presents each block with a valid/ack handshake to the control that drives the permutation core's `Din`/`Din_valid`/`Last_block` inputs.

## Interface
- `WIDTH`, 64: lane width in bits; only 64 is supported.
- `RATE_LANES`, 17: lanes per rate block (1088 bits, SHA3-256). Capacity lanes 17..24 are always zero.
---
- `clk`  in  1: clock, rising edge.
- `nrst`  in  1: reset, synchronous, active-low.
- `in_data`  in  64: message lane. Byte j is at bits [8j+7:8j], little-endian.
- `in_valid`  in  1: `in_data` beat is valid.
- `in_last`  in  1: this beat is the final beat of the message.
- `in_bytes`  in  4: count of valid bytes on a last beat.
  - Legal range 0..8; values 9..15 are treated as 8.
  - Ignored when `in_last`=0 (the beat is a full lane).
- `in_ready`  out  1: beat is accepted when `in_valid` && `in_ready`.
- `Dout`  out  [0:4][0:4][WIDTH-1:0]: block. Lane i maps to `Dout[i%5][i/5]`.
- `out_valid`  out  1: `Dout`/`out_last` are valid and held stable.
- `out_last`  out  1: block is the final (padded) block of the message.
- `out_ack`  in  1: consumer takes the block. Ignored when `out_valid`=0.

## Operation
- **Buffer.** 17-lane register buffer plus a 5-bit lane counter `k` (0..16).
  - Buffer is cleared to zero whenever a new block starts, so unwritten lanes are zero-filled.
- **State FILL** (`in_ready`=1).
  - Non-last beat: write lane k, k++.
    - If k was 16: go to HOLD with `out_last`=0, reset k=0.
  - Last beat, b=`in_bytes` < 8:
    - lane k = data bytes 0..b-1, byte b = 0x06, remaining bytes 0.
    - Go to HOLD with `out_last`=1.
  - Last beat, b=8 and k<16:
    - lane k = data; lane k+1 byte0 = 0x06, written in the same cycle.
    - Go to HOLD with `out_last`=1.
  - Last beat, b=8 and k=16:
    - lane 16 = data; go to HOLD with `out_last`=0 and the `pend` flag set.
- **State HOLD** (`in_ready`=0, `out_valid`=1). On `out_ack`:
  - If `pend`=1: load the extra block (lane0=64'h06, others 0, `out_last`=1), clear `pend`, stay in HOLD.
  - If `pend`=0: clear the buffer, k=0, go to FILL.
- **Final bit.** When `out_last`=1, `Dout` lane 16 bits [63:56] are ORed with 0x80.
  - Implemented on the output mux, not stored in the buffer.
  - If byte 0x06 lands in lane 16 byte 7, that byte reads 0x86.
- **Capacity.** Lanes 17..24 of `Dout` are tied to zero.
- **Reset** (`nrst`=0 at a clock edge, any state, including mid-block or mid-HOLD):
  - state=FILL, k=0, buffer cleared, `pend`=0.
  - `out_valid`=0, `out_last`=0, `Dout`=0.
  - `in_ready`=0 during reset; `in_ready`=1 from the first cycle after `nrst` returns high.
- **Simultaneous events.** `in_valid` during HOLD is not accepted; the beat stays on the bus.

## Timing
- One lane accepted per cycle in FILL; there is no input-side bubble within a block.
- `out_valid` rises on the cycle after the accepting edge of the 17th beat or of the last beat.
- `Dout` and `out_last` are registered and stable for the whole time `out_valid`=1.
- `out_ack` sampled at edge t while `out_valid`=1:
  - No pending extra block: `out_valid`=0 and `in_ready`=1 at t+1.
  - Extra block pending: `out_valid` stays 1 and `Dout` holds the extra block from t+1.
- Throughput per full block: 17 input cycles + HOLD cycles (≥1).
- No combinational path from `in_valid` to `in_ready`, nor from `out_ack` to `out_valid`.

## Structure
- `keccak_pkg` holds:
  - the state typedef `logic [0:4][0:4][63:0]`;
  - `RATE_LANES`;
  - `PAD_DOMAIN`=8'h06 and `PAD_FINAL`=8'h80;
  - the lane-to-(x,y) index function.
- One sub-module, `keccak_pad_lane` (combinational). Inputs: lane, byte count, pad-enable. Output: the masked lane with 0x06 inserted.
- FSM, buffer, counter and `pend` flag live in the top level.

## Test plan
1. **Empty message** (`in_last`=1, `in_bytes`=0 on the first beat) -> one block, `out_last`=1:
   - lane0=64'h06, lane16=64'h8000_0000_0000_0000, all other lanes 0.
2. **"abc"** (`in_data`=64'h636261, `in_bytes`=3) -> one block, `out_last`=1:
   - lane0=64'h0000_0000_0663_6261, lane16=64'h8000_0000_0000_0000.
3. **135-byte message** (16 full lanes + last beat b=7) -> one block:
   - lane16 byte7=0x86, `out_last`=1.
4. **136-byte message** (17 full lanes, last beat b=8):
   - Block 1: data lanes, `out_last`=0.
   - After ack: block 2 at the next cycle with lane0=64'h06, lane16=64'h80<<56, `out_last`=1.
5. **8-byte message** (b=8 at lane0) -> lane0=data, lane1=64'h06, lane16 top byte 0x80.
6. **Backpressure and reset:**
   - Withhold `out_ack` for 10 cycles -> `Dout` stable and `in_ready`=0 throughout.
   - Pull `nrst` low for one edge at beat 5 of the next block -> `out_valid`=0; the following beats start at lane 0 and the block contains no stale data.

Source files
------------

// File: rtl/keccak_pkg.sv
// keccak_pkg: shared state type, padding constants and lane placement for the SHA3-256 absorb path
package keccak_pkg;
    localparam int RATE_LANES = 17;
    localparam logic [7:0] PAD_DOMAIN = 8'h06;
    localparam logic [7:0] PAD_FINAL = 8'h80;
    typedef logic [0:4][0:4][63:0] state_t;
    typedef enum logic {FILL, HOLD} pad_state_e;
    typedef struct packed {
        logic [2:0] x;
        logic [2:0] y;
    } lane_xy_t;
    function automatic lane_xy_t lane_xy(input int i);
        lane_xy.x = 3'(i % 5);
        lane_xy.y = 3'(i / 5);
    endfunction
endpackage

// File: rtl/keccak_pad_lane.sv
// keccak_pad_lane: keeps the first bytes of a lane, drops the domain byte after them, zeroes the rest
module keccak_pad_lane
    import keccak_pkg::*;
(
    input  logic [63:0] lane,
    input  logic [3:0]  bytes,
    input  logic        pad,
    output logic [63:0] padded
);
    always_comb begin
        padded = lane;
        for (int j = 0; j < 8; j++)
            if (pad)
                padded[8*j +: 8] = (j < int'(bytes)) ? lane[8*j +: 8] :
                                   (j == int'(bytes)) ? PAD_DOMAIN : 8'h00;
    end
endmodule

// File: rtl/keccak_pad.sv
// keccak_pad: packs 64-bit message lanes into SHA3-256 rate blocks with 0x06..0x80 padding
module keccak_pad
    import keccak_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic                        clk,
    input  logic                        nrst,
    input  logic [WIDTH-1:0]            in_data,
    input  logic                        in_valid,
    input  logic                        in_last,
    input  logic [3:0]                  in_bytes,
    output logic                        in_ready,
    output logic [0:4][0:4][WIDTH-1:0]  Dout,
    output logic                        out_valid,
    output logic                        out_last,
    input  logic                        out_ack
);
    localparam logic [4:0] LAST_K = 5'(RATE_LANES - 1);

    pad_state_e state_q, state_d;
    logic [0:RATE_LANES-1][63:0] lanes_q;
    logic [4:0] k_q;
    logic pend_q, last_q;
    logic accept, full, block_end;
    logic [63:0] padded;
    lane_xy_t xy;

    keccak_pad_lane u_lane (
        .lane   (in_data),
        .bytes  (in_bytes),
        .pad    (in_last),
        .padded (padded)
    );

    assign accept = in_valid && in_ready;
    assign full = !in_last || in_bytes >= 4'd8;
    assign block_end = in_last || k_q == LAST_K;

    always_comb begin
        in_ready = nrst && state_q == FILL;
        out_valid = state_q == HOLD;
        state_d = (state_q == FILL) ? ((accept && block_end) ? HOLD : FILL)
                                    : ((out_ack && !pend_q) ? FILL : HOLD);
    end

    always_ff @(posedge clk)
        state_q <= nrst ? state_d : FILL;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            lanes_q <= '0;
            k_q <= '0;
            pend_q <= 1'b0;
            last_q <= 1'b0;
        end else if (state_q == HOLD) begin
            if (out_ack) begin
                lanes_q <= '0;
                k_q <= '0;
                last_q <= pend_q;
                pend_q <= 1'b0;
                if (pend_q) lanes_q[0] <= 64'(PAD_DOMAIN);
            end
        end else if (accept) begin
            lanes_q[k_q] <= padded;
            k_q <= (k_q == LAST_K) ? 5'd0 : k_q + 5'd1;
            if (in_last) begin
                // a full final lane pushes the domain byte into the next lane, or into a new block
                if (full && k_q != LAST_K) lanes_q[k_q + 5'd1] <= 64'(PAD_DOMAIN);
                last_q <= !(full && k_q == LAST_K);
                pend_q <= full && k_q == LAST_K;
            end
        end
    end

    always_comb begin
        Dout = '0;
        xy = '0;
        for (int i = 0; i < RATE_LANES; i++) begin
            xy = lane_xy(i);
            Dout[xy.x][xy.y] = (i == RATE_LANES - 1 && last_q) ? (lanes_q[i] | {PAD_FINAL, 56'h0})
                                                               : lanes_q[i];
        end
    end

    assign out_last = last_q;
endmodule

// File: tb/tb_keccak_pad.sv
// tb_keccak_pad: directed messages checked against a byte-level SHA3 pad10*1 model
module tb_keccak_pad;
    import keccak_pkg::*;
    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic nrst = 1'b0;
    logic [63:0] in_data = '0;
    logic in_valid = 1'b0, in_last = 1'b0;
    logic [3:0] in_bytes = '0;
    logic in_ready;
    state_t Dout;
    logic out_valid, out_last;
    logic out_ack = 1'b0;

    int checks = 0, fails = 0;
    bit ack_en = 1'b1, ack_rand = 1'b0;
    state_t exp_q[$];
    bit exp_last[$];
    state_t snap;

    always #5 clk = ~clk;

    keccak_pad #(.WIDTH(64)) dut (
        .clk(clk), .nrst(nrst), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_bytes(in_bytes), .in_ready(in_ready),
        .Dout(Dout), .out_valid(out_valid), .out_last(out_last), .out_ack(out_ack)
    );

    function automatic bq_t mk(input int n);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(8'(i * 13 + n + 1));
        return q;
    endfunction

    // message + 0x06 + zeros up to a multiple of 136 bytes, final byte ORed with 0x80
    function automatic void model(input bq_t msg);
        bq_t p;
        state_t s;
        int nb;
        p = msg;
        p.push_back(8'h06);
        while (p.size() % 136 != 0) p.push_back(8'h00);
        p[p.size() - 1] = p[p.size() - 1] | 8'h80;
        nb = p.size() / 136;
        for (int b = 0; b < nb; b++) begin
            s = '0;
            for (int i = 0; i < 136; i++) s[(i / 8) % 5][(i / 8) / 5][8 * (i % 8) +: 8] = p[136 * b + i];
            exp_q.push_back(s);
            exp_last.push_back(b == nb - 1);
        end
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic beat_wait();
        int t = 0;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                break;
            end
            if (++t > 300) begin
                checks++;
                fails++;
                $display("FAIL beat_timeout: in_ready stayed %b, required 1", in_ready);
                break;
            end
        end
    endtask

    task automatic send(input bq_t msg, input int ovr);
        int n = msg.size();
        int beats = (n == 0) ? 1 : (n + 7) / 8;
        model(msg);
        for (int b = 0; b < beats; b++) begin
            int rem = n - 8 * b;
            logic [63:0] d = {8{8'hA5}};
            for (int j = 0; j < 8 && j < rem; j++) d[8*j +: 8] = msg[8 * b + j];
            in_data = d;
            in_valid = 1'b1;
            in_last = (b == beats - 1);
            in_bytes = in_last ? ((rem >= 8 && ovr > 0) ? 4'(ovr) : 4'(rem)) : 4'd3;
            beat_wait();
        end
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_valid();
        int t = 0;
        do @(negedge clk); while (!out_valid && ++t < 300);
        check("valid_timeout", 64'(out_valid), 64'd1);
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() > 0 && t < 600) begin
            @(posedge clk);
            t++;
        end
        #1;
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    initial forever begin
        @(negedge clk);
        out_ack = 1'b0;
        if (nrst) begin
            checks++;
            if (in_ready !== !out_valid) begin
                fails++;
                $display("FAIL handshake: in_ready=%b out_valid=%b, required complementary", in_ready, out_valid);
            end
            if (out_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_block: out_valid=1, required 0");
                end else begin
                    int bad = -1;
                    for (int i = 0; i < 25; i++)
                        if (bad < 0 && Dout[i % 5][i / 5] !== exp_q[0][i % 5][i / 5]) bad = i;
                    if (bad >= 0 || out_last !== exp_last[0]) begin
                        fails++;
                        if (bad < 0) bad = 0;
                        $display("FAIL block lane%0d got %h expected %h, out_last got %b expected %b",
                                 bad, Dout[bad % 5][bad / 5], exp_q[0][bad % 5][bad / 5], out_last, exp_last[0]);
                    end
                    out_ack = ack_en && (!ack_rand || $urandom_range(0, 1) == 1);
                    if (out_ack) begin
                        void'(exp_q.pop_front());
                        void'(exp_last.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        bq_t m;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_dout_lane0", Dout[0][0], 64'd0);
        check("rst_dout_lane16", Dout[1][3], 64'd0);
        @(posedge clk);
        #1 nrst = 1'b1;
        @(negedge clk);
        check("ready_after_rst", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        ack_en = 1'b0;
        m = {};
        send(m, 0);
        wait_valid();
        check("empty_lane0", Dout[0][0], 64'h06);
        check("empty_lane1", Dout[1][0], 64'h0);
        check("empty_lane16", Dout[1][3], 64'h8000_0000_0000_0000);
        check("empty_last", 64'(out_last), 64'd1);
        ack_en = 1'b1;
        drain();

        ack_en = 1'b0;
        m = {8'h61, 8'h62, 8'h63};
        send(m, 0);
        wait_valid();
        check("abc_model_lane0", exp_q[0][0][0], 64'h0000_0000_0663_6261);
        check("abc_lane0", Dout[0][0], 64'h0000_0000_0663_6261);
        check("abc_lane16", Dout[1][3], 64'h8000_0000_0000_0000);
        ack_en = 1'b1;
        drain();

        ack_en = 1'b0;
        send(mk(135), 0);
        wait_valid();
        check("m135_model_byte", 64'(exp_q[0][1][3][63:56]), 64'h86);
        check("m135_byte7", 64'(Dout[1][3][63:56]), 64'h86);
        check("m135_last", 64'(out_last), 64'd1);
        ack_en = 1'b1;
        drain();

        ack_en = 1'b0;
        send(mk(136), 0);
        wait_valid();
        check("m136_blocks", 64'(exp_q.size()), 64'd2);
        check("m136_model_pad", exp_q[1][0][0], 64'h06);
        check("m136_last0", 64'(out_last), 64'd0);
        ack_en = 1'b1;
        drain();

        ack_en = 1'b0;
        m = mk(8);
        send(m, 0);
        wait_valid();
        check("m8_lane0", Dout[0][0], {m[7], m[6], m[5], m[4], m[3], m[2], m[1], m[0]});
        check("m8_lane1", Dout[1][0], 64'h06);
        check("m8_lane16", Dout[1][3], 64'h8000_0000_0000_0000);
        ack_en = 1'b1;
        drain();

        send(mk(136), 12);
        drain();
        send(mk(128), 0);
        drain();
        send(mk(129), 0);
        drain();
        ack_rand = 1'b1;
        send(mk(272), 0);
        drain();
        send(mk(50), 0);
        drain();
        ack_rand = 1'b0;

        ack_en = 1'b0;
        send(mk(20), 0);
        wait_valid();
        snap = Dout;
        repeat (10) @(negedge clk);
        check("bp_lane0_stable", Dout[0][0], snap[0][0]);
        check("bp_lane2_stable", Dout[2][0], snap[2][0]);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        ack_en = 1'b1;
        drain();

        for (int b = 0; b < 5; b++) begin
            in_data = 64'hDEAD_BEEF_0000_0000 + 64'(b);
            in_valid = 1'b1;
            in_last = 1'b0;
            in_bytes = 4'd8;
            beat_wait();
        end
        in_valid = 1'b0;
        nrst = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1 nrst = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_lane0", Dout[0][0], 64'd0);
        check("midrst_lane4", Dout[4][0], 64'd0);
        check("midrst_in_ready_up", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        send(mk(30), 0);
        drain();

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
